// File: rtl/dim_pole_pkg.sv
// Shared constants, state encoding and length clamp for the dim-pole sample buffer.
package dim_pole_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Requests longer than the buffer read it exactly once.
  function automatic logic [LEN_W-1:0] clamp_length(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/dim_pole_readout_if.sv
// Request, buffer-read and output-stream signals of the readout sequencer.
interface dim_pole_readout_if;
  import dim_pole_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_addr, length, q, out_ready,
    output rdaddress, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, start_addr, length, q, out_ready,
    input  rdaddress, out_data, out_valid, out_last, busy, done
  );

endinterface

// File: rtl/dim_pole_skid_fifo.sv
// Two-entry output FIFO (head + tail register) carrying a last flag per word.
module dim_pole_skid_fifo
  import dim_pole_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic              head_last,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] tail_data;
  logic              tail_valid;
  logic              tail_last;

  // Tail is only ever valid behind a valid head.
  assign occupancy = 2'(head_valid) + 2'(tail_valid);

  // Head always presents the oldest word; last is cleared whenever the head empties.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
      tail_last  <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        head_data  <= tail_data;
        head_last  <= tail_last;
        head_valid <= 1'b1;
        tail_valid <= push;
        tail_last  <= push & push_last;
        if (push) tail_data <= push_data;
      end else begin
        head_valid <= push;
        head_last  <= push & push_last;
        if (push) head_data <= push_data;
      end
    end else if (push) begin
      if (!head_valid) begin
        head_data  <= push_data;
        head_last  <= push_last;
        head_valid <= 1'b1;
      end else begin
        tail_data  <= push_data;
        tail_last  <= push_last;
        tail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dim_pole_readout.sv
// Read-side sequencer: issues circular buffer reads and streams the samples out.
module dim_pole_readout
  import dim_pole_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  dim_pole_readout_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic              inflight_last;
  logic              busy_r;
  logic              done_r;

  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic              head_last;
  logic [1:0]        occupancy;
  logic              pop;
  logic              issue;
  logic [LEN_W-1:0]  req_len;

  assign req_len = clamp_length(bus.length);
  assign pop     = head_valid & bus.out_ready;
  // A slot is free if buffered + in-flight words leave room, or one leaves this cycle.
  assign issue   = (state == ST_READ) &&
                   (((3'(occupancy) + 3'(inflight)) < 3'd2) || pop);

  // Sequencer, address/remaining counters and the one-cycle read-latency tracker.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_W'(1));
      done_r        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            addr      <= bus.start_addr;
            remaining <= req_len;
            busy_r    <= 1'b1;
            if (req_len == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!inflight && ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop))) begin
            state  <= ST_DONE;
            done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dim_pole_skid_fifo u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (inflight),
    .push_data  (bus.q),
    .push_last  (inflight_last),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .head_last  (head_last),
    .occupancy  (occupancy)
  );

  assign bus.rdaddress = addr;
  assign bus.out_data  = head_data;
  assign bus.out_valid = head_valid;
  assign bus.out_last  = head_last;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_dim_pole_readout.sv
// Self-checking bench: synchronous buffer model, request table, random requests, reset abort.
module tb_dim_pole_readout;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dim_pole_readout_if bus ();

  dim_pole_readout dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Synchronous-read buffer: data for an address appears the cycle after it is presented.
  logic [15:0] mem [128];
  logic [15:0] q_reg = 16'h0;
  always @(posedge clock) q_reg <= mem[bus.rdaddress];
  assign bus.q = q_reg;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic pick(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  typedef struct {
    int saddr;
    int len;
    int pct;       // out_ready high probability in percent
    int exp_n;     // words delivered
    int exp_first; // cycle of first transfer (-1: not checked)
    int exp_done;  // cycle of done pulse (-1: not checked)
  } vec_t;

  // Runs one request; expected words come straight from the buffer contents.
  task automatic run_req(input int saddr, input int len, input int pct,
                         input int exp_first, input int exp_done, input bit poke);
    int n, cyc, first_cyc, done_cyc, done_cnt, xfers, issued, max_out;
    int last_bad, stab_bad, addr_bad, busy_bad;
    int exp_q[$];
    int got[$];
    logic prev_stall;
    logic [15:0] prev_data;
    bit exp_busy;
    n = (len > 128) ? 128 : len;
    for (int i = 0; i < n; i++) exp_q.push_back(int'(mem[(saddr + i) % 128]));
    first_cyc = -1; done_cyc = -1; done_cnt = 0; xfers = 0; max_out = 0;
    last_bad = 0; stab_bad = 0; addr_bad = 0; busy_bad = 0;
    prev_stall = 1'b0; prev_data = '0;

    @(negedge clock);
    bus.start      = 1'b1;
    bus.start_addr = 7'(saddr);
    bus.length     = 8'(len);
    bus.out_ready  = pick(pct);
    @(posedge clock);
    for (cyc = 1; cyc <= 4000 && (done_cyc < 0 || cyc < done_cyc + 3); cyc++) begin
      #1;
      bus.start = (poke && cyc == 4);
      if (poke && cyc == 4) begin
        bus.start_addr = 7'd64;
        bus.length     = 8'd8;
      end
      bus.out_ready = pick(pct);
      exp_busy = (done_cyc < 0);
      if (bus.busy !== exp_busy) busy_bad++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) stab_bad++;
      if (bus.out_last !== (bus.out_valid && (xfers + 1 == n))) last_bad++;
      if (pct == 100 && cyc <= n && int'(bus.rdaddress) != (saddr + cyc - 1) % 128) addr_bad++;
      if (n < 128) begin
        issued = (int'(bus.rdaddress) - saddr + 128) % 128;
        if (issued - xfers > max_out) max_out = issued - xfers;
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(int'(bus.out_data));
        if (first_cyc < 0) first_cyc = cyc;
        xfers++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      @(posedge clock);
    end
    bus.start = 1'b0;

    check($sformatf("done_seen a%0d l%0d", saddr, len), int'(done_cyc > 0), 1);
    check($sformatf("word_count a%0d l%0d", saddr, len), got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("data a%0d l%0d w%0d", saddr, len, i), got[i], exp_q[i]);
    check("out_last_placement", last_bad, 0);
    check("stable_while_stalled", stab_bad, 0);
    check("single_done", done_cnt, 1);
    check("busy_window", busy_bad, 0);
    if (exp_first >= 0) check("first_valid_cycle", first_cyc, exp_first);
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    if (pct == 100) check("rdaddress_sequence", addr_bad, 0);
    if (n < 128) check("outstanding_le_2", int'(max_out <= 2), 1);
  endtask

  vec_t vecs[$];

  initial begin
    int xf, done_cnt, len, pct;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'(16'h1000 + i);

    repeat (3) @(posedge clock);
    #1;
    check("reset_rdaddress", int'(bus.rdaddress), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_last", int'(bus.out_last), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clock);
    reset = 1'b0;

    vecs.push_back('{0,   128, 100, 128,  3, 131});
    vecs.push_back('{125, 5,   100, 5,    3, 8});
    vecs.push_back('{126, 4,   100, 4,    3, 7});
    vecs.push_back('{0,   0,   100, 0,   -1, 1});
    vecs.push_back('{0,   200, 100, 128,  3, 131});
    vecs.push_back('{100, 1,   100, 1,    3, 4});
    vecs.push_back('{10,  16,  30,  16,  -1, -1});
    vecs.push_back('{120, 40,  50,  40,  -1, -1});
    foreach (vecs[i]) run_req(vecs[i].saddr, vecs[i].len, vecs[i].pct,
                              vecs[i].exp_first, vecs[i].exp_done, 1'b0);

    // Start pulse mid-request must not disturb it.
    run_req(0, 8, 100, 3, 11, 1'b1);

    // Random contents and requests against the buffer model.
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(200, 0));
      pct = (r % 2 == 0) ? 100 : int'($urandom_range(90, 20));
      run_req(int'($urandom_range(127, 0)), len, pct, -1,
              (pct == 100) ? ((len == 0) ? 1 : ((len > 128 ? 128 : len) + 3)) : -1, 1'b0);
    end

    // Reset after three words of a ten-word request.
    @(negedge clock);
    bus.start = 1'b1; bus.start_addr = 7'd20; bus.length = 8'd10; bus.out_ready = 1'b1;
    @(posedge clock);
    xf = 0;
    for (int c = 1; c < 50 && xf < 3; c++) begin
      #1;
      bus.start = 1'b0;
      if (bus.out_valid && bus.out_ready) xf++;
      @(posedge clock);
    end
    check("reset_abort_words_before", xf, 3);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_rdaddress", int'(bus.rdaddress), 0);
    check("abort_out_data", int'(bus.out_data), 0);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_out_last", int'(bus.out_last), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.out_valid) done_cnt++;
    end
    check("abort_no_done_or_valid", done_cnt, 0);
    run_req(90, 6, 100, 3, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
